// File: rtl/card_pkg.sv
// Shared card definitions: code constants, blank segment pattern and baccarat scoring helpers.
package card_pkg;

  localparam logic [3:0] CARD_A  = 4'd1;
  localparam logic [3:0] CARD_2  = 4'd2;
  localparam logic [3:0] CARD_3  = 4'd3;
  localparam logic [3:0] CARD_4  = 4'd4;
  localparam logic [3:0] CARD_5  = 4'd5;
  localparam logic [3:0] CARD_6  = 4'd6;
  localparam logic [3:0] CARD_7  = 4'd7;
  localparam logic [3:0] CARD_8  = 4'd8;
  localparam logic [3:0] CARD_9  = 4'd9;
  localparam logic [3:0] CARD_10 = 4'd10;
  localparam logic [3:0] CARD_J  = 4'd11;
  localparam logic [3:0] CARD_Q  = 4'd12;
  localparam logic [3:0] CARD_K  = 4'd13;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    PH_SHOW = 1'b0,
    PH_HIDE = 1'b1
  } phase_e;

  function automatic logic card_is_valid(input logic [3:0] code);
    return (code >= CARD_A) && (code <= CARD_K);
  endfunction

  // Tens and court cards count zero; invalid codes also yield zero.
  function automatic logic [3:0] baccarat_value(input logic [3:0] code);
    return ((code >= CARD_A) && (code <= CARD_9)) ? code : 4'd0;
  endfunction

  function automatic logic [3:0] add_mod10(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum >= 5'd10) ? 4'(sum - 5'd10) : sum[3:0];
  endfunction

endpackage

// File: rtl/card7seg.sv
// Card code to active-low 7-segment glyph; unused codes (including empty) show blank.
module card7seg
  import card_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      CARD_A:  seg = 7'b1111001;
      CARD_2:  seg = 7'b0100100;
      CARD_3:  seg = 7'b0110000;
      CARD_4:  seg = 7'b0011001;
      CARD_5:  seg = 7'b0010010;
      CARD_6:  seg = 7'b0000010;
      CARD_7:  seg = 7'b1111000;
      CARD_8:  seg = 7'b0000000;
      CARD_9:  seg = 7'b0010000;
      CARD_10: seg = 7'b1000000;
      CARD_J:  seg = 7'b1100001;
      CARD_Q:  seg = 7'b0011000;
      CARD_K:  seg = 7'b0001001;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/card_hand_display.sv
// Holds a dealt hand of up to NUM_SLOTS cards, tracks the baccarat score and
// drives one HEX display per slot, optionally blinking the newest card.
module card_hand_display
  import card_pkg::*;
#(
  parameter int NUM_SLOTS  = 3,
  parameter int BLINK_HALF = 25_000_000
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  input  logic [3:0]                       in_card,
  output logic                             in_ready,
  input  logic                             clear,
  input  logic                             blink_en,
  output logic [7*NUM_SLOTS-1:0]           hex_out,
  output logic [$clog2(NUM_SLOTS+1)-1:0]   count,
  output logic [3:0]                       score,
  output logic                             err
);

  localparam int CNTW = $clog2(NUM_SLOTS + 1);
  localparam int BW   = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CNTW-1:0] FULL      = CNTW'(NUM_SLOTS);
  localparam logic [BW-1:0]   BLINK_MAX = BW'(BLINK_HALF - 1);

  logic [3:0]      slot_reg [NUM_SLOTS];
  logic [CNTW-1:0] count_reg;
  logic [3:0]      score_reg;
  logic            err_reg;
  logic [BW-1:0]   blink_cnt_reg;
  phase_e          phase_reg;

  logic            accept;
  logic            hide_last;
  logic [CNTW-1:0] last_idx;
  logic [6:0]      dec_seg [NUM_SLOTS];

  assign in_ready = (count_reg < FULL);
  assign accept   = in_valid && in_ready && !clear && card_is_valid(in_card);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_reg     <= '0;
      score_reg     <= '0;
      err_reg       <= 1'b0;
      blink_cnt_reg <= '0;
      phase_reg     <= PH_SHOW;
    end else begin
      // Invalid codes are flagged even when the hand is full.
      err_reg <= in_valid && !card_is_valid(in_card);
      if (accept) begin
        count_reg     <= count_reg + 1'b1;
        score_reg     <= add_mod10(score_reg, baccarat_value(in_card));
        blink_cnt_reg <= '0;
        phase_reg     <= PH_SHOW;
      end else if (blink_cnt_reg == BLINK_MAX) begin
        blink_cnt_reg <= '0;
        phase_reg     <= (phase_reg == PH_SHOW) ? PH_HIDE : PH_SHOW;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + 1'b1;
      end
    end
  end

  assign last_idx  = count_reg - 1'b1;
  assign hide_last = blink_en && (phase_reg == PH_HIDE) && (count_reg != '0);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (reset || clear) begin
          slot_reg[gi] <= 4'd0;
        end else if (accept && (count_reg == CNTW'(gi))) begin
          slot_reg[gi] <= in_card;
        end
      end

      card7seg u_dec (
        .code (slot_reg[gi]),
        .seg  (dec_seg[gi])
      );

      // Empty slots hold code 0, which the decoder already renders blank.
      assign hex_out[7*gi +: 7] = (hide_last && (last_idx == CNTW'(gi))) ? SEG_BLANK : dec_seg[gi];
    end
  endgenerate

  assign count = count_reg;
  assign score = score_reg;
  assign err   = err_reg;

endmodule

// File: tb/tb_card_hand_display.sv
// Randomized plus directed bench for card_hand_display against a queue-based hand model.
module tb_card_hand_display;

  localparam int NS = 3;
  localparam int BH = 4;

  logic          clk = 1'b0;
  logic          reset, in_valid, clear, blink_en;
  logic [3:0]    in_card;
  logic          in_ready, err;
  logic [7*NS-1:0] hex_out;
  logic [1:0]    count;
  logic [3:0]    score;

  int checks   = 0;
  int failures = 0;

  logic [6:0] glyph [0:15];
  int  mcards[$];
  int  mscore;
  bit  merr;
  int  mt;

  card_hand_display #(.NUM_SLOTS(NS), .BLINK_HALF(BH)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_card  (in_card),
    .in_ready (in_ready),
    .clear    (clear),
    .blink_en (blink_en),
    .hex_out  (hex_out),
    .count    (count),
    .score    (score),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7*NS-1:0] model_hex();
    logic [7*NS-1:0] h;
    bit hidden;
    hidden = blink_en && (mcards.size() > 0) && (((mt / BH) % 2) == 1);
    for (int k = 0; k < NS; k++) begin
      if (k < mcards.size() && !(hidden && k == mcards.size() - 1))
        h[7*k +: 7] = glyph[mcards[k]];
      else
        h[7*k +: 7] = 7'b1111111;
    end
    return h;
  endfunction

  // Apply one cycle of inputs, advance the model on the edge, then compare all outputs.
  task automatic cyc(input logic r, input logic c, input logic v, input logic [3:0] card, input logic b);
    bit ok_code;
    reset = r; clear = c; in_valid = v; in_card = card; blink_en = b;
    @(posedge clk);
    ok_code = (card >= 1) && (card <= 13);
    if (r || c) begin
      mcards.delete();
      mscore = 0;
      merr = 1'b0;
      mt = 0;
    end else begin
      merr = v && !ok_code;
      if (v && ok_code && mcards.size() < NS) begin
        mcards.push_back(int'(card));
        mscore = (mscore + ((card <= 9) ? int'(card) : 0)) % 10;
        mt = 0;
      end else begin
        mt = (mt + 1) % (2 * BH);
      end
    end
    #1;
    check_val("count", 32'(count), 32'(mcards.size()));
    check_val("score", 32'(score), 32'(mscore));
    check_val("err", 32'(err), 32'(merr));
    check_val("in_ready", 32'(in_ready), 32'(mcards.size() < NS));
    check_val("hex_out", 32'(hex_out), 32'(model_hex()));
  endtask

  initial begin
    glyph[0]  = 7'b1111111; glyph[1]  = 7'b1111001; glyph[2]  = 7'b0100100; glyph[3]  = 7'b0110000;
    glyph[4]  = 7'b0011001; glyph[5]  = 7'b0010010; glyph[6]  = 7'b0000010; glyph[7]  = 7'b1111000;
    glyph[8]  = 7'b0000000; glyph[9]  = 7'b0010000; glyph[10] = 7'b1000000; glyph[11] = 7'b1100001;
    glyph[12] = 7'b0011000; glyph[13] = 7'b0001001; glyph[14] = 7'b1111111; glyph[15] = 7'b1111111;
    mscore = 0; merr = 1'b0; mt = 0;
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_card = 4'd0; blink_en = 1'b0;

    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 5, 0);
    check_val("reset_hex", 32'(hex_out), 32'h1FFFFF);
    check_val("reset_ready", 32'(in_ready), 32'd1);

    // Deal 9, 8, K: score 7, full hand.
    cyc(0, 0, 1, 9, 0);
    cyc(0, 0, 1, 8, 0);
    cyc(0, 0, 1, 13, 0);
    check_val("deal_hex", 32'(hex_out), 32'({7'b0001001, 7'b0000000, 7'b0010000}));
    check_val("deal_score", 32'(score), 32'd7);
    check_val("deal_ready", 32'(in_ready), 32'd0);

    cyc(0, 0, 1, 5, 0);
    check_val("full_err", 32'(err), 32'd0);
    check_val("full_count", 32'(count), 32'd3);

    cyc(0, 0, 1, 14, 0);
    check_val("err14", 32'(err), 32'd1);
    cyc(0, 0, 1, 0, 0);
    check_val("err0", 32'(err), 32'd1);
    cyc(0, 0, 0, 0, 0);
    check_val("err_drop", 32'(err), 32'd0);

    // Clear with a simultaneous offer drops the offer.
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 2, 0);
    cyc(0, 0, 1, 3, 0);
    cyc(0, 1, 1, 4, 0);
    check_val("clr_count", 32'(count), 32'd0);
    check_val("clr_hex", 32'(hex_out), 32'h1FFFFF);

    // Blink: 4 cycles shown, 4 hidden; reload restarts the show phase.
    cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 1, 1, 1);
    for (int i = 0; i < 11; i++) cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 2, 1);
    check_val("reload_show", 32'(hex_out[13:7]), 32'(7'b0100100));
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);

    // Glyph and value sweep.
    for (int c = 1; c <= 13; c++) begin
      cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 1, 4'(c), 0);
      check_val("sweep_glyph", 32'(hex_out[6:0]), 32'(glyph[c]));
      check_val("sweep_score", 32'(score), 32'((c <= 9) ? c : 0));
    end

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      logic r, c, v, b;
      r = ($urandom_range(99) < 2);
      c = ($urandom_range(99) < 8);
      v = ($urandom_range(99) < 60);
      b = blink_en;
      if ($urandom_range(31) == 0) b = ~b;
      cyc(r, c, v, 4'($urandom_range(15)), b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
